op_rx_framed: RTL
=================

Name: op_rx_framed

Overview:
- Parametrised serial receiver for the host-to-FPGA command link; next generation of the 4-bit op-code receiver.
- Adds proper start/stop framing, mid-bit sampling, an input synchroniser, configurable word width and parity, and a one-cycle valid strobe with error flags.
- Sits between the board RX pin and the command decoder.
- Decoded words feed the op dispatch logic through the shared op type when DATA_BITS equals the op width.

Parameters:
- CLK_BAUD_RATIO, 8: clock cycles per bit; legal range >= 4.
- DATA_BITS, 8: payload bits per frame, LSB first; legal range 1..32.
- PARITY_MODE, PARITY_NONE: one of PARITY_NONE, PARITY_EVEN or PARITY_ODD, from comms_pkg.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-high.
- rx_in  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  last good payload; held between frames.
- valid_out  output  1  one-cycle pulse; data_out was updated this cycle.
- frame_err_out  output  1  one-cycle pulse; stop bit sampled low.
- parity_err_out  output  1  one-cycle pulse; parity mismatch.
- busy_out  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset: the single clock is clk_in and reset is asynchronous, active-high on rst_in. Any assertion, including mid-frame, immediately forces:
  - FSM to IDLE;
  - data_out = 0;
  - valid_out, frame_err_out, parity_err_out, busy_out = 0;
  - synchroniser flops = 1.
  - The partial frame is discarded.
- Synchroniser: rx_in passes through 2 flops to give rx_s. Adds 2 cycles of latency.
- Counters:
  - Baud counter width is $clog2(CLK_BAUD_RATIO). HALF = (CLK_BAUD_RATIO-1)/2.
  - Bit index width is $clog2(DATA_BITS+1).
- IDLE: when rx_s = 0, go to START and clear the baud counter.
- START: increment the counter. At count == HALF, sample rx_s:
  - 0: go to DATA, clear counter and bit index.
  - 1: glitch; return to IDLE with no flags.
- DATA:
  - Counter wraps at CLK_BAUD_RATIO-1. Sample on the wrap.
  - Each sample shifts rx_s into the shift register at the MSB, shift right, so the first bit received lands at bit 0.
  - Running parity accumulates each sampled bit.
  - After DATA_BITS samples, go to PARITY if PARITY_MODE != PARITY_NONE, else to STOP.
- PARITY: sample on the wrap. Compare the sampled bit with the expected value:
  - even: XOR of data bits;
  - odd: inverse of that XOR.
  - Latch any mismatch, then go to STOP.
- STOP: sample on the wrap.
  - rx_s = 1 and no parity mismatch: data_out <= shift register, valid_out = 1 next cycle, go to IDLE.
  - rx_s = 1 with parity mismatch: parity_err_out = 1, data_out unchanged, go to IDLE.
  - rx_s = 0: frame_err_out = 1 (takes priority over parity error), data_out unchanged, go to BREAK.
- BREAK: wait for rx_s = 1, then go to IDLE. This prevents a held-low line being decoded as back-to-back 0x00 frames.
- Output timing:
  - All outputs are registered.
  - valid_out and the error pulses never coincide, and each lasts exactly 1 cycle.
- Latency: with rx_in first sampled low at edge t0, the STOP sample occurs at edge t0 + 2 + HALF + CLK_BAUD_RATIO*(DATA_BITS+1+P), where P = 1 if parity is enabled, else 0. The pulse is visible during the following cycle.
- Back-to-back frames: IDLE is reentered in the cycle after the STOP sample. A start edge arriving HALF cycles after the nominal stop centre must be accepted.

Decomposition:
- comms_pkg holds:
  - op typedef;
  - parity_mode_e (PARITY_NONE, PARITY_EVEN, PARITY_ODD);
  - rx_state_e (IDLE, START, DATA, PARITY, STOP, BREAK);
  - shared constant DEFAULT_CLK_BAUD_RATIO = 8.
- One sub-module, sync_2ff: a 2-flop synchroniser with parametrised reset value, reused for other async inputs.

Test Plan:
- Basic frame: RATIO=8, DATA_BITS=8, no parity; send 0xA5 with 1 stop bit, start edge sampled at t0 -> valid_out high for 1 cycle after edge t0+77, data_out=0xA5, no error flags.
- Two back-to-back frames, 0x00 then 0xFF, no idle gap -> two valid pulses 80 cycles apart, data_out=0x00 then 0xFF.
- Start glitch: rx_in low for 2 cycles only -> returns to IDLE, busy_out drops, no valid or error pulse; the next frame 0x3C is received correctly.
- Framing error: 0x5A with stop bit driven low, line then held low 40 cycles, then high -> frame_err_out pulse once, data_out keeps its previous value, no further frames until the line goes high.
- Parity errors, DATA_BITS=4, RATIO=16:
  - even parity, 4'b1011 with parity bit 1 -> valid_out, data_out=4'b1011.
  - same frame with parity bit 0 -> parity_err_out pulse, data_out unchanged.
- Reset mid-frame: assert rst_in asynchronously during bit 3 of 0xC3 -> all outputs 0 within the same cycle. After release, a full frame 0x81 -> valid_out, data_out=0x81.

Source files
------------

// File: rtl/comms_pkg.sv
// Shared types and constants for the host command link receivers.
package comms_pkg;

   localparam int OP_BITS                = 4;
   localparam int DEFAULT_CLK_BAUD_RATIO = 8;

   typedef logic [OP_BITS-1:0] op_t;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_EVEN = 2'd1,
      PARITY_ODD  = 2'd2
   } parity_mode_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_e;

   function automatic logic parity_bit_expected(input parity_mode_e mode, input logic data_xor);
      case (mode)
         PARITY_ODD: parity_bit_expected = ~data_xor;
         default:    parity_bit_expected = data_xor;
      endcase
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value selects the idle level.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // two-stage capture of the asynchronous input
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         meta_r <= RESET_VAL;
         sync_r <= RESET_VAL;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/op_rx_framed.sv
// Framed serial receiver: start/stop framing, mid-bit sampling, optional parity, one-cycle status pulses.
module op_rx_framed
   import comms_pkg::*;
#(
   parameter int           CLK_BAUD_RATIO = DEFAULT_CLK_BAUD_RATIO,
   parameter int           DATA_BITS      = 8,
   parameter parity_mode_e PARITY_MODE    = PARITY_NONE
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid_out,
   output logic                 frame_err_out,
   output logic                 parity_err_out,
   output logic                 busy_out
);

   localparam int CW   = $clog2(CLK_BAUD_RATIO);
   localparam int BW   = $clog2(DATA_BITS + 1);
   localparam int HALF = (CLK_BAUD_RATIO - 1) / 2;

   localparam logic [CW-1:0] HALF_CNT = CW'(HALF);
   localparam logic [CW-1:0] WRAP_CNT = CW'(CLK_BAUD_RATIO - 1);
   localparam logic [BW-1:0] LAST_IDX = BW'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_e            state_r;
   logic [CW-1:0]        cnt_r;
   logic [CW-1:0]        cnt_inc_s;
   logic                 wrap_s;
   logic [BW-1:0]        idx_r;
   logic [DATA_BITS-1:0] shift_r;
   logic [DATA_BITS-1:0] shift_next_s;
   logic                 par_r;
   logic                 par_err_r;
   logic [DATA_BITS-1:0] data_r;
   logic                 valid_r;
   logic                 ferr_r;
   logic                 perr_r;
   logic                 busy_r;

   sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .d      (rx_in),
      .q      (rx_s)
   );

   assign cnt_inc_s = cnt_r + 1'b1;
   assign wrap_s    = (cnt_r == WRAP_CNT);

   // LSB-first: each new bit enters at the MSB so the first bit ends at bit 0
   always_comb begin
      shift_next_s                = shift_r >> 1'b1;
      shift_next_s[DATA_BITS-1]   = rx_s;
   end

   // receive FSM with registered data and status outputs
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         idx_r     <= '0;
         shift_r   <= '0;
         par_r     <= 1'b0;
         par_err_r <= 1'b0;
         data_r    <= '0;
         valid_r   <= 1'b0;
         ferr_r    <= 1'b0;
         perr_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         perr_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (!rx_s) begin
                  state_r <= START;
                  busy_r  <= 1'b1;
                  cnt_r   <= '0;
               end
            end
            START: begin
               if (cnt_inc_s == HALF_CNT) begin
                  if (!rx_s) begin
                     state_r   <= DATA;
                     cnt_r     <= '0;
                     idx_r     <= '0;
                     par_r     <= 1'b0;
                     par_err_r <= 1'b0;
                  end else begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            DATA: begin
               if (wrap_s) begin
                  cnt_r   <= '0;
                  shift_r <= shift_next_s;
                  par_r   <= par_r ^ rx_s;
                  if (idx_r == LAST_IDX) begin
                     state_r <= (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
                  end else begin
                     idx_r <= idx_r + 1'b1;
                  end
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            PARITY: begin
               if (wrap_s) begin
                  cnt_r     <= '0;
                  par_err_r <= (rx_s != parity_bit_expected(PARITY_MODE, par_r));
                  state_r   <= STOP;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            STOP: begin
               if (wrap_s) begin
                  cnt_r <= '0;
                  // a low stop bit outranks a parity mismatch and parks in BREAK until the line recovers
                  if (!rx_s) begin
                     ferr_r  <= 1'b1;
                     state_r <= BREAK;
                  end else if (par_err_r) begin
                     perr_r  <= 1'b1;
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end else begin
                     data_r  <= shift_r;
                     valid_r <= 1'b1;
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            BREAK: begin
               if (rx_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out       = data_r;
   assign valid_out      = valid_r;
   assign frame_err_out  = ferr_r;
   assign parity_err_out = perr_r;
   assign busy_out       = busy_r;

endmodule
